// File: rtl/alu_share_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// slave = arbiter view; master = requesters plus ALU view.
interface alu_share_arbiter_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [XLEN-1:0]   req0_in1;
   logic [XLEN-1:0]   req0_in2;
   logic [CTRL_W-1:0] req0_ctrl;
   logic              req1_valid;
   logic              req1_ready;
   logic [XLEN-1:0]   req1_in1;
   logic [XLEN-1:0]   req1_in2;
   logic [CTRL_W-1:0] req1_ctrl;
   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [XLEN-1:0]   rsp_out;
   logic              rsp_zero;
   logic [XLEN-1:0]   alu_in1;
   logic [XLEN-1:0]   alu_in2;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [XLEN-1:0]   alu_out;
   logic              alu_zero;

   modport slave (
      input  req0_valid, req0_in1, req0_in2, req0_ctrl,
      input  req1_valid, req1_in1, req1_in2, req1_ctrl,
      input  rsp0_ready, rsp1_ready, alu_out, alu_zero,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_out, rsp_zero, alu_in1, alu_in2, alu_ctrl
   );

   modport master (
      output req0_valid, req0_in1, req0_in2, req0_ctrl,
      output req1_valid, req1_in1, req1_in2, req1_ctrl,
      output rsp0_ready, rsp1_ready, alu_out, alu_zero,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_out, rsp_zero, alu_in1, alu_in2, alu_ctrl
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters; one op in flight,
// registered result returned over valid/ready. ALU_ARB_FIXED_PRIO_EN makes requester 0 win ties.
module alu_share_arbiter #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_share_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              gnt_id;
   logic [XLEN-1:0]   op_in1;
   logic [XLEN-1:0]   op_in2;
   logic [CTRL_W-1:0] op_ctrl;
   logic [XLEN-1:0]   rsp_out_q;
   logic              rsp_zero_q;
   logic              rsp_hs;
   logic              arb_en;
   logic              win;
   logic              req0_hs;
   logic              req1_hs;
   logic              accept;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic              last_grant;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      rsp_hs         = 1'b0;
      arb_en         = 1'b0;
      win            = 1'b0;
      req0_hs        = 1'b0;
      req1_hs        = 1'b0;
      accept         = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;

      if (state == RESP) begin
         bus.rsp0_valid = ~gnt_id;
         bus.rsp1_valid = gnt_id;
         rsp_hs = gnt_id ? bus.rsp1_ready : bus.rsp0_ready;
      end

`ifdef ALU_ARB_FIXED_PRIO_EN
      win = (bus.req0_valid & bus.req1_valid) ? 1'b0 : bus.req1_valid;
`else
      win = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
`endif
      // rst_n gating lets the readies fall the instant reset asserts
      arb_en  = rst_n & ((state == IDLE) | rsp_hs);
      req0_hs = arb_en & bus.req0_valid & ~win;
      req1_hs = arb_en & bus.req1_valid & win;
      accept  = req0_hs | req1_hs;

      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_id     <= 1'b0;
         op_in1     <= '0;
         op_in2     <= '0;
         op_ctrl    <= '0;
         rsp_out_q  <= '0;
         rsp_zero_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         if (accept) begin
            gnt_id  <= win;
            op_in1  <= win ? bus.req1_in1  : bus.req0_in1;
            op_in2  <= win ? bus.req1_in2  : bus.req0_in2;
            op_ctrl <= win ? bus.req1_ctrl : bus.req0_ctrl;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= win;
`endif
         end
         if (state == EXEC) begin
            rsp_out_q  <= bus.alu_out;
            rsp_zero_q <= bus.alu_zero;
         end
      end
   end

   // ALU inputs come only from latched operands, never straight from requesters
   assign bus.alu_in1    = op_in1;
   assign bus.alu_in2    = op_in2;
   assign bus.alu_ctrl   = op_ctrl;
   assign bus.rsp_out    = rsp_out_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.req0_ready = req0_hs;
   assign bus.req1_ready = req1_hs;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_alu_share_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   alu_share_arbiter_if #(.XLEN(32), .CTRL_W(4)) bus ();

   alu_share_arbiter #(.XLEN(32), .CTRL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {zero, result}
   function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
      logic [31:0] r;
      logic        z;
      r = 32'd0;
      z = 1'b0;
      case (c)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a << b[4:0];
         4'd3:  r = {31'd0, $signed(a) < $signed(b)};
         4'd4:  r = {31'd0, a < b};
         4'd5:  r = a ^ b;
         4'd6:  r = a >> b[4:0];
         4'd7:  r = $signed(a) >>> b[4:0];
         4'd8:  r = a | b;
         4'd9:  r = a & b;
         4'd10: z = (a == b);
         4'd11: z = (a != b);
         4'd12: z = ($signed(a) < $signed(b));
         4'd13: z = ($signed(a) >= $signed(b));
         4'd14: z = (a < b);
         default: z = (a >= b);
      endcase
      if (c < 4'd10) z = (r == 32'd0);
      return {z, r};
   endfunction

   assign {bus.alu_zero, bus.alu_out} = alu_f(bus.alu_in1, bus.alu_in2, bus.alu_ctrl);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one outstanding op; 'age' counts edges since acceptance
   bit          m_busy = 1'b0;
   int          m_age = 0;
   bit          m_owner = 1'b0;
   bit          m_last = 1'b1;
   logic [31:0] m_in1, m_in2, m_out;
   logic [3:0]  m_ctrl;
   logic        m_zero;

   always @(negedge clk) begin
      bit win, rv0, rv1, rdy0, rdy1, can_acc;
      logic [32:0] res;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
         chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
         chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
         chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
         chk("rst_rsp_out", bus.rsp_out, 32'd0);
         chk("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
         chk("rst_alu_in1", bus.alu_in1, 32'd0);
         chk("rst_alu_in2", bus.alu_in2, 32'd0);
         chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
      end else begin
         rv0 = m_busy && m_age >= 1 && !m_owner;
         rv1 = m_busy && m_age >= 1 && m_owner;
         can_acc = !m_busy || (rv0 && bus.rsp0_ready) || (rv1 && bus.rsp1_ready);
         if (bus.req0_valid && bus.req1_valid) win = FIXED ? 1'b0 : !m_last;
         else                                  win = bus.req1_valid;
         rdy0 = can_acc && bus.req0_valid && !win;
         rdy1 = can_acc && bus.req1_valid && win;
         chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, rdy0});
         chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, rdy1});
         chk("rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, rv0});
         chk("rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, rv1});
         if (rv0 || rv1) begin
            chk("rsp_out", bus.rsp_out, m_out);
            chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, m_zero});
         end
         if (m_busy && m_age == 0) begin
            chk("alu_in1", bus.alu_in1, m_in1);
            chk("alu_in2", bus.alu_in2, m_in2);
            chk("alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, m_ctrl});
         end
         if ((rv0 && bus.rsp0_ready) || (rv1 && bus.rsp1_ready)) m_busy = 1'b0;
         else if (m_busy) m_age++;
         if (rdy0 || rdy1) begin
            m_busy  = 1'b1;
            m_age   = 0;
            m_owner = win;
            m_last  = win;
            m_in1   = win ? bus.req1_in1  : bus.req0_in1;
            m_in2   = win ? bus.req1_in2  : bus.req0_in2;
            m_ctrl  = win ? bus.req1_ctrl : bus.req0_ctrl;
            res     = alu_f(m_in1, m_in2, m_ctrl);
            m_out   = res[31:0];
            m_zero  = res[32];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.req0_valid = v;
      bus.req0_ctrl  = c;
      bus.req0_in1   = a;
      bus.req0_in2   = b;
   endtask

   task automatic set1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.req1_valid = v;
      bus.req1_ctrl  = c;
      bus.req1_in1   = a;
      bus.req1_in2   = b;
   endtask

   initial begin
      bit g, pg;
      set0(1'b0, 4'd0, 32'd0, 32'd0);
      set1(1'b0, 4'd0, 32'd0, 32'd0);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;

      // req0 alone: 5 + 7
      set0(1'b1, 4'd0, 32'd5, 32'd7);
      mid(); chk("t1_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      tick(); set0(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      mid();
      chk("t1_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t1_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
      chk("t1_rsp_out", bus.rsp_out, 32'd12);
      chk("t1_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
      tick();

      // req1 branch compare: -1 < 1 signed
      set1(1'b1, 4'd12, 32'hFFFF_FFFF, 32'd1);
      mid(); chk("t3_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
      tick(); set1(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      mid();
      chk("t3_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("t3_rsp_zero", {31'd0, bus.rsp_zero}, 32'd1);
      chk("t3_rsp_out", bus.rsp_out, 32'd0);
      tick();

      // both valid, held: grants alternate (last grant was 1)
      set0(1'b1, 4'd1, 32'd10, 32'd3);
      set1(1'b1, 4'd2, 32'd1, 32'd4);
      pg = 1'b0;
      for (int k = 0; k < 4; k++) begin
         g = FIXED ? 1'b0 : k[0];
         mid();
         chk("t2_grant_ready", {31'd0, g ? bus.req1_ready : bus.req0_ready}, 32'd1);
         chk("t2_other_ready", {31'd0, g ? bus.req0_ready : bus.req1_ready}, 32'd0);
         if (k > 0) chk("t2_rsp_out", bus.rsp_out, pg ? 32'd16 : 32'd7);
         pg = g;
         tick();
         if (k == 3) begin
            set0(1'b0, 4'd0, 32'd0, 32'd0);
            set1(1'b0, 4'd0, 32'd0, 32'd0);
         end
         tick();
      end
      mid(); chk("t2_last_rsp_out", bus.rsp_out, pg ? 32'd16 : 32'd7);
      tick();

      // response backpressure on rsp0 while req1 waits
      bus.rsp0_ready = 1'b0;
      set0(1'b1, 4'd0, 32'd1, 32'd2);
      mid(); chk("t4_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      tick();
      set0(1'b0, 4'd0, 32'd0, 32'd0);
      set1(1'b1, 4'd9, 32'h0000_F0F0, 32'h0000_FF00);
      tick();
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("t4_hold_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
         chk("t4_hold_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
         chk("t4_hold_rsp_out", bus.rsp_out, 32'd3);
         tick();
      end
      bus.rsp0_ready = 1'b1;
      mid(); chk("t4_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
      tick(); set1(1'b0, 4'd0, 32'd0, 32'd0);
      mid();
      chk("t4_exec_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd9);
      chk("t4_exec_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      tick();
      mid();
      chk("t4_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("t4_rsp_out", bus.rsp_out, 32'h0000_F000);
      tick();

      // reset during EXEC; afterwards requester 0 wins the tie
      set0(1'b1, 4'd0, 32'd2, 32'd2);
      mid(); chk("t5_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      tick();
      set1(1'b1, 4'd0, 32'd3, 32'd3);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      chk("t5_async_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      chk("t5_async_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      chk("t5_async_alu_in1", bus.alu_in1, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      mid();
      chk("t5_tie_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      chk("t5_tie_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      tick();
      set0(1'b0, 4'd0, 32'd0, 32'd0);
      set1(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      mid(); chk("t5_rsp_out", bus.rsp_out, 32'd4);
      tick();

      // arithmetic shift right through the arbiter
      set0(1'b1, 4'd7, 32'h8000_0000, 32'd4);
      mid(); chk("t6_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      tick(); set0(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      mid();
      chk("t6_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t6_rsp_out", bus.rsp_out, 32'hF800_0000);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
